picomem_arbiter_2_1: RTL and testbench
======================================

# picomem_arbiter_2_1

- Two-master, one-slave PicoMem arbiter that lets the CPU and a second bus master (DMA or LCD frame fetcher) share one PicoMem slave, such as PSRAM.
- Sits between the masters and the slave-side port of the 1:4 address mux.
- Grants whole transactions using round-robin priority.
- Bounds each slave transaction with a watchdog that returns an error word if the slave never responds.

## Interface
Parameters:
- TIMEOUT, 16'd1024: maximum BUSY cycles without `s_ready` before the error response fires; 0 disables the watchdog; legal range 0..65535.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timeout.

Ports:
- clk  in  1  system clock; the only clock.
- resetn  in  1  reset; asynchronous, active-low.
- m0_valid / m1_valid  in  1  master request.
- m0_ready / m1_ready  out  1  transaction complete.
- m0_addr, m0_wdata / m1_addr, m1_wdata  in  32  address and write data.
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 means read.
- m0_rdata / m1_rdata  out  32  read data.
- s_valid  out  1  request to the slave.
- s_ready  in  1  slave done.
- s_addr, s_wdata  out  32  address and write data to the slave.
- s_wstrb  out  4  byte strobes to the slave.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 0 when idle.
- timeout_err  out  1  one-cycle pulse on a watchdog expiry.

## Operation
- Registered state: IDLE, BUSY0 or BUSY1; a `last` pointer (1 bit); a 16-bit cycle counter `cnt`.
- **IDLE:**
  - All outputs are 0.
  - Only m0_valid set -> BUSY0.
  - Only m1_valid set -> BUSY1.
  - Both set -> the master that is not `last` is granted.
- **BUSY_n, datapath:**
  - s_valid = mn_valid.
  - s_addr / s_wdata / s_wstrb = master n's fields.
  - mn_ready = s_ready.
  - mn_rdata = s_rdata.
  - The other master sees ready = 0 and rdata = 0.
  - All of this is combinational from the state register.
- **BUSY_n, exits:**
  - Normal completion: s_ready = 1 -> IDLE, `last` <= n.
  - Abort: mn_valid drops without s_ready (a protocol violation) -> s_valid falls the same cycle, next state is IDLE, `last` is unchanged.
  - Watchdog: TIMEOUT != 0, cnt == TIMEOUT and s_ready = 0. In that cycle:
    - s_valid forced to 0;
    - mn_ready = 1 and mn_rdata = ERR_RDATA;
    - timeout_err = 1;
    - next state is IDLE and `last` <= n.
- **Counter:**
  - Cleared on entry to BUSY.
  - Increments each BUSY cycle without s_ready.
  - Saturates at 16'hFFFF.
- **Fairness:** after a completed m0 transaction, a tie goes to m1, and vice versa. A lone requester is always granted regardless of `last`.
- **Reset (asserted at any time, including mid-transaction):**
  - State IDLE, `last` = 1 (m0 wins the first tie), cnt = 0.
  - grant, timeout_err, s_valid and both ready outputs are 0 immediately.
  - Slave-side data outputs are 0.

## Timing
- **Arbitration latency:** 1 cycle. Request sampled at edge t -> s_valid and grant high during cycle t+1.
- **Zero-wait slave** (s_ready tied or combinational 1): mn_ready is high in cycle t+1, so the arbiter adds exactly 1 cycle to each access.
- **Minimum gap:** one IDLE cycle between consecutive grants. Peak rate is one transaction per 2 cycles when the slave is zero-wait.
- **Watchdog:** s_valid is high for exactly TIMEOUT cycles (cnt 0..TIMEOUT-1). The error response follows in the next cycle.
- **Simultaneous events:**
  - s_ready arriving in the cycle cnt == TIMEOUT takes precedence: a normal completion, no error.
  - A new request arriving in the completion cycle is not granted until the following edge, from IDLE.
- **Bus ownership:**
  - Once a master is granted, grant and the slave-side address/data mux do not change until the state leaves BUSY.
  - A request from the other master never preempts the current transaction.

## Test plan
- **Single read, m0:**
  - Stimulus: m0 reads 0x4000_0010; slave returns 0x1234_5678 with 3 wait states.
  - Required: grant = 01 from cycle t+1; m0_ready is a single pulse with m0_rdata = 0x1234_5678; m1_ready stays 0.
- **Tie, round-robin:**
  - Stimulus: m0 and m1 hold valid continuously; zero-wait slave.
  - Required: the grant sequence after reset is m0, m1, m0, m1. Each master sees ready every 4 cycles, and each grant is separated by one IDLE cycle.
- **Lone requester:**
  - Stimulus: m1 issues 4 back-to-back writes, wstrb = 4'hF.
  - Required: all 4 are granted to m1; s_wstrb = F and s_wdata match m1's fields; one idle cycle between each.
- **Timeout:**
  - Stimulus: TIMEOUT = 4; slave never readies; m0 reads.
  - Required: s_valid is high for 4 cycles. In the 5th cycle, m0_ready = 1, m0_rdata = 0xDEAD_BEEF, timeout_err = 1 and s_valid = 0. Next state is IDLE.
- **Ready at expiry:**
  - Stimulus: TIMEOUT = 4; s_ready arrives in the cycle cnt == 4.
  - Required: a normal response with s_rdata and no timeout_err.
- **Reset mid-transaction:**
  - Stimulus: drop resetn while BUSY1 is waiting on the slave.
  - Required: s_valid, m1_ready and grant go to 0 asynchronously. After release, a tie is granted to m0 first.

Source files
------------

// File: rtl/picomem_arbiter_2_1.sv
// Two-master round-robin PicoMem arbiter with a slave watchdog.
// Grants whole transactions; answers ERR_RDATA if the slave stalls too long.
module picomem_arbiter_2_1 #(
  parameter logic [15:0] TIMEOUT   = 16'd1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic        sel;
  logic        mv;
  logic        tmo;
  logic        rdy;
  logic [31:0] rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel = (state_q == BUSY1);
  assign mv  = sel ? m1_valid : m0_valid;
  // s_ready in the expiry cycle wins over the watchdog
  assign tmo = (TIMEOUT != 16'd0) &&
               (cnt_q == TIMEOUT) && !s_ready;
  assign rdy = s_ready || tmo;
  assign rd  = tmo ? ERR_RDATA : s_rdata;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    s_valid     = 1'b0;
    s_addr      = 32'd0;
    s_wdata     = 32'd0;
    s_wstrb     = 4'd0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = 32'd0;
    m1_rdata    = 32'd0;
    grant       = 2'b00;
    timeout_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        unique case (1'b1)
          m0_valid && (!m1_valid || last_q):
            state_d = BUSY0;
          m1_valid && (!m0_valid || !last_q):
            state_d = BUSY1;
          default: state_d = IDLE;
        endcase
      end
      BUSY0, BUSY1: begin
        grant       = {sel, !sel};
        s_valid     = mv && !tmo;
        s_addr      = sel ? m1_addr  : m0_addr;
        s_wdata     = sel ? m1_wdata : m0_wdata;
        s_wstrb     = sel ? m1_wstrb : m0_wstrb;
        timeout_err = tmo;
        if (sel) begin
          m1_ready = rdy;
          m1_rdata = rd;
        end else begin
          m0_ready = rdy;
          m0_rdata = rd;
        end
        if (rdy) begin
          state_d = IDLE;
          last_d  = sel;
        end else if (!mv) begin
          state_d = IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// Scoreboard bench for picomem_arbiter_2_1 (TIMEOUT = 4).
// Grants and responses are queued at stimulus time, checked by monitors.
module tb_picomem_arbiter_2_1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } gexp_t;

  typedef struct {
    bit          m;
    logic [31:0] rd;
    bit          err;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    gstart[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [1:0] prev_g = 2'b00;

  int          slv_wait = 0;
  bit          slv_never = 1'b0;
  logic [31:0] slv_data = 32'd0;
  int          scnt;

  picomem_arbiter_2_1 #(.TIMEOUT(16'd4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // slave model: ready after slv_wait stalled cycles of ownership
  always @(posedge clk or negedge resetn) begin
    if (!resetn) scnt <= 0;
    else if (grant != 2'b00 && !s_ready) scnt <= scnt + 1;
    else scnt <= 0;
  end

  assign s_ready = (grant != 2'b00) && !slv_never &&
                   (scnt == slv_wait);
  assign s_rdata = slv_data;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    gexp_t ge;
    rexp_t re;
    if (grant != 2'b00 && prev_g == 2'b00) begin
      gstart.push_back(cyc);
      if (gq.size() == 0) begin
        chk("gnt_unexp", {30'd0, grant}, 32'd0);
      end else begin
        ge = gq.pop_front();
        chk("gnt", {30'd0, grant}, {30'd0, ge.g});
        chk("s_addr", s_addr, ge.a);
        chk("s_wdata", s_wdata, ge.d);
        chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, ge.s});
      end
    end
    if (m0_ready || m1_ready) begin
      if (rq.size() == 0) begin
        chk("rdy_unexp", {30'd0, m1_ready, m0_ready}, 32'd0);
      end else begin
        re = rq.pop_front();
        chk("rdy_who", {30'd0, m1_ready, m0_ready},
            re.m ? 32'd2 : 32'd1);
        chk("rdata", re.m ? m1_rdata : m0_rdata, re.rd);
        chk("other_rdata", re.m ? m0_rdata : m1_rdata, 32'd0);
        chk("tmo_err", {31'd0, timeout_err}, {31'd0, re.err});
        chk("s_valid_done", {31'd0, s_valid}, {31'd0, !re.err});
      end
    end else begin
      chk("tmo_err_idle", {31'd0, timeout_err}, 32'd0);
    end
    prev_g <= grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((rq.size() != 0 || gq.size() != 0) && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_left", rq.size() + gq.size(), 32'd0);
  endtask

  task automatic push_g(input logic [1:0] g, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    gexp_t e;
    e.g = g; e.a = a; e.d = d; e.s = s;
    gq.push_back(e);
  endtask

  task automatic push_r(input bit m, input logic [31:0] rd,
                        input bit err);
    rexp_t e;
    e.m = m; e.rd = rd; e.err = err;
    rq.push_back(e);
  endtask

  task automatic check_gaps(input string tag, input int n);
    chk({tag, "_cnt"}, gstart.size(), n);
    for (int i = 1; i < gstart.size(); i++)
      chk({tag, "_gap"}, gstart[i] - gstart[i-1], 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sv;
    int n;
    bit got;

    resetn   = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr  = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr  = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_sv", {31'd0, s_valid}, 32'd0);
    chk("rst_rdy", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_saddr", s_addr, 32'd0);
    tick();
    resetn = 1'b1;

    // single m0 read, 3 wait states
    slv_wait = 3;
    slv_data = 32'h1234_5678;
    push_g(2'b01, 32'h4000_0010, 32'd0, 4'h0);
    push_r(1'b0, 32'h1234_5678, 1'b0);
    m0_addr  = 32'h4000_0010;
    m0_valid = 1'b1;
    @(negedge clk);
    chk("lat_idle", {30'd0, grant}, 32'd0);
    @(negedge clk);
    chk("lat_gnt", {30'd0, grant}, 32'd1);
    chk("lat_sv", {31'd0, s_valid}, 32'd1);
    drain(20);
    tick();
    m0_valid = 1'b0;

    // tie after reset: m0, m1, m0, m1
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    slv_wait = 0;
    slv_data = 32'hA5A5_0002;
    gstart.delete();
    m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_0000;
    m1_addr = 32'h0000_0200; m1_wdata = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        push_g(2'b01, m0_addr, m0_wdata, 4'h0);
        push_r(1'b0, slv_data, 1'b0);
      end else begin
        push_g(2'b10, m1_addr, m1_wdata, 4'h0);
        push_r(1'b1, slv_data, 1'b0);
      end
    end
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    drain(40);
    tick();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    check_gaps("tie", 4);

    // lone m1 writer, 4 back-to-back writes
    slv_data = 32'h0BAD_F00D;
    gstart.delete();
    for (int i = 0; i < 4; i++) begin
      m1_addr  = 32'h3000_0000 + 32'(4 * i);
      m1_wdata = 32'hC0DE_0000 + 32'(i);
      m1_wstrb = 4'hF;
      push_g(2'b10, m1_addr, m1_wdata, 4'hF);
      push_r(1'b1, slv_data, 1'b0);
      m1_valid = 1'b1;
      drain(20);
      tick();
    end
    m1_valid = 1'b0;
    m1_wstrb = 4'h0;
    check_gaps("wr", 4);

    // watchdog expiry on m0 read
    slv_never = 1'b1;
    m0_addr = 32'h5000_0000;
    push_g(2'b01, m0_addr, m0_wdata, 4'h0);
    push_r(1'b0, 32'hDEAD_BEEF, 1'b1);
    m0_valid = 1'b1;
    sv = 0; n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      #1;
      if (m0_ready) got = 1'b1;
      else if (s_valid) sv++;
      n++;
    end
    chk("tmo_seen", {31'd0, got}, 32'd1);
    chk("tmo_sv_cycles", sv, 32'd4);
    tick();
    m0_valid = 1'b0;
    @(negedge clk);
    chk("tmo_idle", {30'd0, grant}, 32'd0);
    slv_never = 1'b0;
    drain(5);

    // ready arrives exactly in the expiry cycle
    slv_wait = 4;
    slv_data = 32'h5A5A_0005;
    m0_addr  = 32'h5000_0040;
    tick();
    push_g(2'b01, m0_addr, m0_wdata, 4'h0);
    push_r(1'b0, slv_data, 1'b0);
    m0_valid = 1'b1;
    drain(20);
    tick();
    m0_valid = 1'b0;

    // reset while m1 waits on the slave
    slv_never = 1'b1;
    m1_addr = 32'h6000_0000;
    tick();
    push_g(2'b10, m1_addr, m1_wdata, 4'h0);
    m1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sv", {31'd0, s_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_sv", {31'd0, s_valid}, 32'd0);
    chk("arst_rdy", {31'd0, m1_ready}, 32'd0);
    chk("arst_grant", {30'd0, grant}, 32'd0);
    slv_never = 1'b0;
    slv_wait  = 0;
    slv_data  = 32'h7777_0006;
    m0_addr   = 32'h6000_0100;
    push_g(2'b01, m0_addr, m0_wdata, 4'h0);
    push_r(1'b0, slv_data, 1'b0);
    push_g(2'b10, m1_addr, m1_wdata, 4'h0);
    push_r(1'b1, slv_data, 1'b0);
    m0_valid = 1'b1;
    tick();
    resetn = 1'b1;
    drain(30);
    tick();
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
